// File: rtl/updown_count_arbiter.sv
// Round-robin arbiter that shares one up/down step counter between two requesters,
// issuing one registered pulse per step and mirroring the counter value locally.
module updown_count_arbiter #(
  parameter int W = 8,
  parameter int S = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req0_dir,
  input  logic [S-1:0] req0_steps,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic         req1_dir,
  input  logic [S-1:0] req1_steps,
  output logic         req1_ready,
  input  logic         hold,
  output logic         cnt_up,
  output logic         cnt_down,
  output logic [W-1:0] count,
  output logic         busy,
  output logic [1:0]   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [S-1:0] STEP_ONE  = {{(S-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] COUNT_ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_nextState;
  logic         r_dir;
  logic         r_grant;
  logic         r_lastServed;
  logic         r_up;
  logic         r_down;
  logic [S-1:0] r_remaining;
  logic [W-1:0] r_count;

  logic         w_pick1;
  logic         w_accept;
  logic         w_selDir;
  logic [S-1:0] w_selSteps;
  logic         w_step;
  logic         w_lastStep;
  logic         w_pulseNext;
  logic         w_nextDir;

  // Requester 1 wins when it is alone, or when both ask and requester 0 went last.
  always_comb begin
    w_pick1     = req1_valid && (!req0_valid || !r_lastServed);
    w_accept    = (r_state == IDLE) && !reset && (req0_valid || req1_valid);
    w_selDir    = w_pick1 ? req1_dir : req0_dir;
    w_selSteps  = w_pick1 ? req1_steps : req0_steps;
    w_step      = r_up || r_down;
    w_lastStep  = w_step && (r_remaining == STEP_ONE);
    w_pulseNext = (w_nextState == RUN) && !hold;
    w_nextDir   = (r_state == IDLE) ? w_selDir : r_dir;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = (w_selSteps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_accept && !w_pick1;
    req1_ready = w_accept && w_pick1;
    busy       = (r_state != IDLE);
    done       = (r_state == DONE) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  end

  // A pulse issued for a cycle always lands in the mirror at that cycle's closing edge,
  // so hold only suppresses pulses that have not been issued yet.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_count      <= '0;
      r_remaining  <= '0;
      r_dir        <= 1'b0;
      r_grant      <= 1'b0;
      r_lastServed <= 1'b1;
    end else begin
      r_up   <= w_pulseNext && w_nextDir;
      r_down <= w_pulseNext && !w_nextDir;
      if (w_accept) begin
        r_dir       <= w_selDir;
        r_grant     <= w_pick1;
        r_remaining <= w_selSteps;
      end else if (w_step) begin
        r_remaining <= r_remaining - STEP_ONE;
      end
      if (w_step) begin
        r_count <= r_up ? (r_count + COUNT_ONE) : (r_count - COUNT_ONE);
      end
      if (r_state == DONE) begin
        r_lastServed <= r_grant;
      end
    end
  end

  assign cnt_up   = r_up;
  assign cnt_down = r_down;
  assign count    = r_count;

endmodule

// File: tb/tb_updown_count_arbiter.sv
// Testbench for updown_count_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-by-cycle behavioural model.
module tb_updown_count_arbiter;

  localparam int W = 8;
  localparam int S = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0Valid;
  logic         req0Dir;
  logic [S-1:0] req0Steps;
  logic         req0Ready;
  logic         req1Valid;
  logic         req1Dir;
  logic [S-1:0] req1Steps;
  logic         req1Ready;
  logic         hold;
  logic         cntUp;
  logic         cntDown;
  logic [W-1:0] count;
  logic         busy;
  logic [1:0]   done;

  int compared   = 0;
  int mismatched = 0;

  updown_count_arbiter #(.W(W), .S(S)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0Valid),
    .req0_dir   (req0Dir),
    .req0_steps (req0Steps),
    .req0_ready (req0Ready),
    .req1_valid (req1Valid),
    .req1_dir   (req1Dir),
    .req1_steps (req1Steps),
    .req1_ready (req1Ready),
    .hold       (hold),
    .cnt_up     (cntUp),
    .cnt_down   (cntDown),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic goEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic atSample();
    @(negedge clock);
  endtask

  task automatic driveIdle();
    req0Valid = 1'b0;
    req0Dir   = 1'b0;
    req0Steps = '0;
    req1Valid = 1'b0;
    req1Dir   = 1'b0;
    req1Steps = '0;
    hold      = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    driveIdle();
    goEdge();
    goEdge();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    driveIdle();
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    goEdge();
    atSample();
    compared++;
    if ({req0Ready, req1Ready} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b want 00", {req0Ready, req1Ready});
    end
    compared++;
    if (count !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_count: got %0d want 0", count);
    end
    compared++;
    if ({cntUp, cntDown, busy, done} !== 5'b00000) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b want 00000", {cntUp, cntDown, busy, done});
    end
    goEdge();
    reset = 1'b0;
    driveIdle();
  endtask

  task automatic test_basic_up();
    doReset();
    req0Valid = 1'b1;
    req0Dir   = 1'b1;
    req0Steps = 4'd3;
    atSample();
    compared++;
    if ({req0Ready, req1Ready, busy} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL basic_handshake: got %b want 100", {req0Ready, req1Ready, busy});
    end
    for (int i = 1; i <= 3; i++) begin
      goEdge();
      if (i == 2) begin
        req0Dir   = 1'b0;
        req0Steps = 4'd7;
      end
      atSample();
      compared++;
      if ({cntUp, cntDown, req0Ready, busy} !== 4'b1001) begin
        mismatched++;
        $display("[TB] FAIL basic_pulse%0d: got %b want 1001", i, {cntUp, cntDown, req0Ready, busy});
      end
      compared++;
      if (count !== W'(i - 1)) begin
        mismatched++;
        $display("[TB] FAIL basic_count%0d: got %0d want %0d", i, count, i - 1);
      end
    end
    goEdge();
    req0Valid = 1'b0;
    atSample();
    compared++;
    if ({done, cntUp, cntDown, busy, req0Ready} !== 6'b010010 || count !== 8'd3) begin
      mismatched++;
      $display("[TB] FAIL basic_done: got done=%b up=%b dn=%b busy=%b rdy=%b count=%0d want 01/0/0/1/0/3",
               done, cntUp, cntDown, busy, req0Ready, count);
    end
    goEdge();
    atSample();
    compared++;
    if ({done, busy, req0Ready} !== 4'b0000 || count !== 8'd3) begin
      mismatched++;
      $display("[TB] FAIL basic_idle: got done=%b busy=%b rdy=%b count=%0d want 00/0/0/3",
               done, busy, req0Ready, count);
    end
    goEdge();
  endtask

  task automatic test_both_valid();
    doReset();
    req0Valid = 1'b1;
    req0Dir   = 1'b1;
    req0Steps = 4'd2;
    req1Valid = 1'b1;
    req1Dir   = 1'b0;
    req1Steps = 4'd1;
    atSample();
    compared++;
    if ({req0Ready, req1Ready} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL both_first_grant: got %b want 10", {req0Ready, req1Ready});
    end
    goEdge();
    req0Valid = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      atSample();
      compared++;
      if ({cntUp, cntDown, req1Ready} !== 3'b100) begin
        mismatched++;
        $display("[TB] FAIL both_pulse%0d: got %b want 100", t, {cntUp, cntDown, req1Ready});
      end
      goEdge();
    end
    atSample();
    compared++;
    if (done !== 2'b01 || count !== 8'd2 || req1Ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL both_done0: got done=%b count=%0d rdy1=%b want 01/2/0", done, count, req1Ready);
    end
    goEdge();
    atSample();
    compared++;
    if ({req0Ready, req1Ready, busy} !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL both_second_grant: got %b want 010", {req0Ready, req1Ready, busy});
    end
    goEdge();
    req1Valid = 1'b0;
    atSample();
    compared++;
    if ({cntUp, cntDown} !== 2'b01 || count !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL both_down_pulse: got %b count=%0d want 01/2", {cntUp, cntDown}, count);
    end
    goEdge();
    atSample();
    compared++;
    if (done !== 2'b10 || count !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL both_done1: got done=%b count=%0d want 10/1", done, count);
    end
    goEdge();
  endtask

  task automatic test_wrap();
    doReset();
    req1Valid = 1'b1;
    req1Dir   = 1'b0;
    req1Steps = 4'd2;
    atSample();
    compared++;
    if ({req0Ready, req1Ready} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL wrap_grant: got %b want 01", {req0Ready, req1Ready});
    end
    goEdge();
    req1Valid = 1'b0;
    atSample();
    compared++;
    if ({cntUp, cntDown} !== 2'b01 || count !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL wrap_step1: got %b count=%0d want 01/0", {cntUp, cntDown}, count);
    end
    goEdge();
    atSample();
    compared++;
    if ({cntUp, cntDown} !== 2'b01 || count !== 8'd255) begin
      mismatched++;
      $display("[TB] FAIL wrap_step2: got %b count=%0d want 01/255", {cntUp, cntDown}, count);
    end
    goEdge();
    atSample();
    compared++;
    if ({cntUp, cntDown} !== 2'b00 || done !== 2'b10 || count !== 8'd254) begin
      mismatched++;
      $display("[TB] FAIL wrap_done: got %b done=%b count=%0d want 00/10/254", {cntUp, cntDown}, done, count);
    end
    goEdge();
  endtask

  task automatic test_zero_steps();
    doReset();
    req0Valid = 1'b1;
    req0Dir   = 1'b1;
    req0Steps = 4'd0;
    atSample();
    compared++;
    if ({req0Ready, req1Ready} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL zero_grant: got %b want 10", {req0Ready, req1Ready});
    end
    goEdge();
    req0Valid = 1'b0;
    atSample();
    compared++;
    if ({done, cntUp, cntDown, busy} !== 5'b01001 || count !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL zero_done: got %b count=%0d want 01001/0", {done, cntUp, cntDown, busy}, count);
    end
    goEdge();
    atSample();
    compared++;
    if ({done, busy} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL zero_idle: got %b want 000", {done, busy});
    end
    goEdge();
  endtask

  task automatic test_hold();
    int pulsesSoFar;
    bit expUp;
    doReset();
    pulsesSoFar = 0;
    req0Valid = 1'b1;
    req0Dir   = 1'b1;
    req0Steps = 4'd4;
    atSample();
    for (int t = 1; t <= 9; t++) begin
      goEdge();
      req0Valid = 1'b0;
      hold      = (t >= 2 && t <= 4);
      atSample();
      expUp = (t == 1 || t == 2 || t == 6 || t == 7);
      compared++;
      if ({cntUp, cntDown} !== {expUp, 1'b0} || count !== W'(pulsesSoFar)
          || done !== ((t == 8) ? 2'b01 : 2'b00) || busy !== (t <= 8)) begin
        mismatched++;
        $display("[TB] FAIL hold_t%0d: got up=%b dn=%b count=%0d done=%b busy=%b want up=%b dn=0 count=%0d done=%b busy=%b",
                 t, cntUp, cntDown, count, done, busy, expUp, pulsesSoFar,
                 (t == 8) ? 2'b01 : 2'b00, (t <= 8));
      end
      if (expUp) pulsesSoFar++;
    end
    hold = 1'b0;
    goEdge();
  endtask

  task automatic test_reset_mid_run();
    doReset();
    req0Valid = 1'b1;
    req0Dir   = 1'b1;
    req0Steps = 4'd5;
    atSample();
    goEdge();
    req0Valid = 1'b0;
    goEdge();
    goEdge();
    reset = 1'b1;
    atSample();
    compared++;
    if (count !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL midreset_before: got count=%0d want 2", count);
    end
    goEdge();
    reset = 1'b0;
    for (int t = 4; t <= 8; t++) begin
      atSample();
      compared++;
      if ({cntUp, cntDown, busy, done} !== 5'b00000 || count !== 8'd0) begin
        mismatched++;
        $display("[TB] FAIL midreset_t%0d: got %b count=%0d want 00000/0", t, {cntUp, cntDown, busy, done}, count);
      end
      goEdge();
    end
  endtask

  // The model tracks the command in flight as a step budget plus the pulse due this cycle.
  task automatic test_random();
    int  mCount, mLast, mLeft, mPulse, mOwner, mSign;
    bit  mActive, mDoneNow, pick1;
    logic [1:0] expReady, expUpDown, expDone;
    doReset();
    mCount = 0; mLast = 1; mLeft = 0; mPulse = 0; mOwner = 0; mSign = 1;
    mActive = 1'b0; mDoneNow = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset     = ($urandom_range(0, 79) == 0);
      req0Valid = 1'($urandom_range(0, 1));
      req0Dir   = 1'($urandom_range(0, 1));
      req0Steps = ($urandom_range(0, 3) == 0) ? S'($urandom_range(0, 15)) : S'($urandom_range(0, 3));
      req1Valid = 1'($urandom_range(0, 1));
      req1Dir   = 1'($urandom_range(0, 1));
      req1Steps = ($urandom_range(0, 3) == 0) ? S'($urandom_range(0, 15)) : S'($urandom_range(0, 3));
      hold      = ($urandom_range(0, 3) == 0);

      pick1     = req1Valid && (!req0Valid || mLast == 0);
      expReady  = (!reset && !mActive && (req0Valid || req1Valid)) ? (pick1 ? 2'b01 : 2'b10) : 2'b00;
      expUpDown = {mPulse > 0, mPulse < 0};
      expDone   = mDoneNow ? ((mOwner == 1) ? 2'b10 : 2'b01) : 2'b00;

      atSample();
      compared++;
      if ({req0Ready, req1Ready} !== expReady) begin
        mismatched++;
        $display("[TB] FAIL rand_ready c%0d: got %b want %b", cyc, {req0Ready, req1Ready}, expReady);
      end
      compared++;
      if ({cntUp, cntDown} !== expUpDown) begin
        mismatched++;
        $display("[TB] FAIL rand_pulse c%0d: got %b want %b", cyc, {cntUp, cntDown}, expUpDown);
      end
      compared++;
      if (count !== W'(mCount)) begin
        mismatched++;
        $display("[TB] FAIL rand_count c%0d: got %0d want %0d", cyc, count, mCount);
      end
      compared++;
      if ({busy, done} !== {mActive, expDone}) begin
        mismatched++;
        $display("[TB] FAIL rand_status c%0d: got %b want %b", cyc, {busy, done}, {mActive, expDone});
      end

      if (reset) begin
        mCount = 0; mLast = 1; mLeft = 0; mPulse = 0;
        mActive = 1'b0; mDoneNow = 1'b0;
      end else if (!mActive) begin
        if (req0Valid || req1Valid) begin
          mOwner  = pick1 ? 1 : 0;
          mSign   = (pick1 ? req1Dir : req0Dir) ? 1 : -1;
          mLeft   = int'(pick1 ? req1Steps : req0Steps);
          mActive = 1'b1;
          if (mLeft == 0) begin
            mDoneNow = 1'b1;
            mPulse   = 0;
          end else begin
            mPulse = hold ? 0 : mSign;
          end
        end
      end else if (mDoneNow) begin
        mDoneNow = 1'b0;
        mActive  = 1'b0;
        mLast    = mOwner;
      end else begin
        if (mPulse != 0) begin
          mCount = (mCount + mPulse + 256) % 256;
          mLeft--;
        end
        if (mLeft == 0) begin
          mDoneNow = 1'b1;
          mPulse   = 0;
        end else begin
          mPulse = hold ? 0 : mSign;
        end
      end
      goEdge();
    end
    reset = 1'b0;
    driveIdle();
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_both_valid();
    test_wrap();
    test_zero_steps();
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guards against a stalled run so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
